// File: rtl/md_pkg.sv
// Shared HI/LO command encodings, widths and payload types for the multiply/divide unit.
package md_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned RD_W   = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] HILO_OP_NONE  = 3'b000;
  localparam logic [OP_W-1:0] HILO_OP_MULT  = 3'b001;
  localparam logic [OP_W-1:0] HILO_OP_MULTU = 3'b010;
  localparam logic [OP_W-1:0] HILO_OP_DIV   = 3'b011;
  localparam logic [OP_W-1:0] HILO_OP_DIVU  = 3'b100;
  localparam logic [OP_W-1:0] HILO_OP_MTHI  = 3'b101;
  localparam logic [OP_W-1:0] HILO_OP_MTLO  = 3'b110;

  localparam logic [RD_W-1:0] HILO_RD_HI = 2'b10;
  localparam logic [RD_W-1:0] HILO_RD_LO = 2'b01;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_pair_t;

  // True for the four multi-cycle operations
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == HILO_OP_MULT) || (op == HILO_OP_MULTU) ||
           (op == HILO_OP_DIV)  || (op == HILO_OP_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit result for mult/multu/div/divu; zero divisor keeps the current HI/LO.
module md_arith
  import md_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] cur_hi,
  input  logic [DATA_W-1:0] cur_lo,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  logic                     b_zero;
  logic [DATA_W-1:0]        b_safe;
  logic signed [2*DATA_W-1:0] sa64, sb64;
  logic signed [DATA_W:0]   sa33, sb33;

  // Operand preparation; divisor forced to 1 when zero so no X/trap reaches the dividers
  always_comb begin
    b_zero = (b == '0);
    b_safe = b_zero ? DATA_W'(1) : b;
    sa64   = {{DATA_W{a[DATA_W-1]}}, a};
    sb64   = {{DATA_W{b[DATA_W-1]}}, b};
    // 33-bit signed divide keeps 0x80000000 / -1 representable before truncation
    sa33   = {a[DATA_W-1], a};
    sb33   = {b_safe[DATA_W-1], b_safe};
  end

  // Result select per operation
  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      HILO_OP_MULT:  {res_hi, res_lo} = sa64 * sb64;
      HILO_OP_MULTU: {res_hi, res_lo} = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      HILO_OP_DIV: begin
        if (!b_zero) begin
          res_lo = DATA_W'(sa33 / sb33);
          res_hi = DATA_W'(sa33 % sb33);
        end
      end
      HILO_OP_DIVU: begin
        if (!b_zero) begin
          res_lo = a / b_safe;
          res_hi = a % b_safe;
        end
      end
      default: begin
        res_hi = cur_hi;
        res_lo = cur_lo;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models multi-cycle latency and requests stalls.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [OP_W-1:0]   hilo_op,
  input  logic [RD_W-1:0]   hilo_read,
  input  logic              is_hilo,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              start,
  output logic              busy,
  output logic              stall_req,
  output logic [DATA_W-1:0] hilo_out
);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  hilo_pair_t         hilo_q, hilo_d;
  hilo_pair_t         pend_q, pend_d;
  hilo_pair_t         arith_res;

  md_arith u_arith (
    .op     (hilo_op),
    .a      (src_a),
    .b      (src_b),
    .cur_hi (hilo_q.hi),
    .cur_lo (hilo_q.lo),
    .res_hi (arith_res.hi),
    .res_lo (arith_res.lo)
  );

  // State, counter, HI/LO and pending result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      hilo_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      hilo_q  <= hilo_d;
      pend_q  <= pend_d;
    end
  end

  // Accept in IDLE, count down in BUSY, commit pending result on the last busy edge
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    hilo_d  = hilo_q;
    pend_d  = pend_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start = is_muldiv(hilo_op);
        if (start) begin
          pend_d  = arith_res;
          count_d = ((hilo_op == HILO_OP_MULT) || (hilo_op == HILO_OP_MULTU))
                    ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end else if (hilo_op == HILO_OP_MTHI) begin
          hilo_d.hi = src_a;
        end else if (hilo_op == HILO_OP_MTLO) begin
          hilo_d.lo = src_a;
        end
      end
      ST_BUSY: begin
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          hilo_d  = pend_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hazard request and HI/LO read port
  always_comb begin
    busy      = busy_q;
    stall_req = (start | busy_q) & is_hilo;
    case (hilo_read)
      HILO_RD_HI: hilo_out = hilo_q.hi;
      HILO_RD_LO: hilo_out = hilo_q.lo;
      default:    hilo_out = '0;
    endcase
  end

endmodule
